serial_sub: RTL and testbench

SERIAL_SUB -- requirements
Module: serial_sub

---
 rtl/serial_sub_pkg.sv | 14 +
 rtl/serial_sub_fullsub.sv | 21 ++
 rtl/serial_sub.sv | 125 ++++++++++++
 tb/tb_serial_sub.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtractor.
//   WIDTH_DEFAULT : default operand/result width
//   state_t       : control FSM state encoding
package serial_sub_pkg;

  localparam int unsigned WIDTH_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage : serial_sub_pkg

// File: rtl/serial_sub_fullsub.sv
// One-bit full subtractor, gate level, purely combinational.
//   a, b : operand bits (computes a - b - bi)
//   bi   : borrow in
//   d    : difference bit
//   bo   : borrow out
module fullsub (
  input  logic a,
  input  logic b,
  input  logic bi,
  output logic d,
  output logic bo
);

  logic a_x_b;

  assign a_x_b = a ^ b;
  assign d     = a_x_b ^ bi;
  // Borrow when a=0,b=1, or when a==b and a borrow is already pending.
  assign bo    = (~a & b) | (~a_x_b & bi);

endmodule : fullsub

// File: rtl/serial_sub.sv
// Bit-serial subtractor: diff = a - b, one bit per clock, LSB first.
//   clk, reset : clock, synchronous active-high reset
//   start      : begin an operation (accepted only in IDLE)
//   a, b       : minuend / subtrahend, sampled on the accepting edge
//   busy       : high while bits are processed
//   done       : one-cycle pulse when diff/bout/ovf are valid
//   diff       : a - b modulo 2^WIDTH
//   bout       : final borrow (a < b unsigned)
//   ovf        : signed overflow of a - b
module serial_sub
  import serial_sub_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf
);

  localparam int unsigned CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_t           state, state_n;
  logic [WIDTH-1:0] a_sh, a_sh_n;
  logic [WIDTH-1:0] b_sh, b_sh_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             borrow, borrow_n;
  logic             a_msb, a_msb_n;
  logic             b_msb, b_msb_n;
  logic [WIDTH-1:0] diff_n;
  logic             bout_n, ovf_n;
  logic             bit_d, bit_bo;

  // Bit cell operates on the current LSBs of the operand shift registers.
  fullsub u_cell (
    .a  (a_sh[0]),
    .b  (b_sh[0]),
    .bi (borrow),
    .d  (bit_d),
    .bo (bit_bo)
  );

  // Next-state and datapath update.
  always_comb begin
    state_n  = state;
    a_sh_n   = a_sh;
    b_sh_n   = b_sh;
    cnt_n    = cnt;
    borrow_n = borrow;
    a_msb_n  = a_msb;
    b_msb_n  = b_msb;
    diff_n   = diff;
    bout_n   = bout;
    ovf_n    = ovf;
    unique case (state)
      IDLE: begin
        if (start) begin
          a_sh_n   = a;
          b_sh_n   = b;
          a_msb_n  = a[WIDTH-1];
          b_msb_n  = b[WIDTH-1];
          cnt_n    = '0;
          borrow_n = 1'b0;
          state_n  = RUN;
        end
      end
      RUN: begin
        a_sh_n   = a_sh >> 1;
        b_sh_n   = b_sh >> 1;
        diff_n   = {bit_d, diff[WIDTH-1:1]};
        borrow_n = bit_bo;
        if (cnt == CNT_LAST) begin
          // The bit produced now is the result MSB.
          cnt_n   = '0;
          bout_n  = bit_bo;
          ovf_n   = (a_msb != b_msb) & (bit_d != a_msb);
          state_n = DONE;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // State and output registers; busy/done track the state being entered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      a_sh   <= '0;
      b_sh   <= '0;
      cnt    <= '0;
      borrow <= 1'b0;
      a_msb  <= 1'b0;
      b_msb  <= 1'b0;
      diff   <= '0;
      bout   <= 1'b0;
      ovf    <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      state  <= state_n;
      a_sh   <= a_sh_n;
      b_sh   <= b_sh_n;
      cnt    <= cnt_n;
      borrow <= borrow_n;
      a_msb  <= a_msb_n;
      b_msb  <= b_msb_n;
      diff   <= diff_n;
      bout   <= bout_n;
      ovf    <= ovf_n;
      busy   <= (state_n == RUN);
      done   <= (state_n == DONE);
    end
  end

endmodule : serial_sub

// File: tb/tb_serial_sub.sv
// Self-checking bench for serial_sub (WIDTH=8) against an arithmetic model.
module tb_serial_sub;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [W-1:0] a, b;
  logic         busy, done;
  logic [W-1:0] diff;
  logic         bout, ovf;

  int checks = 0;
  int errors = 0;

  serial_sub #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .bout  (bout),
    .ovf   (ovf)
  );

  always #5 clk = ~clk;

  // Reference model: plain integer arithmetic.
  function automatic logic [W-1:0] m_diff(input logic [W-1:0] x, input logic [W-1:0] y);
    int r;
    r = (int'(x) - int'(y) + 256) % 256;
    return W'(r);
  endfunction

  function automatic logic m_bout(input logic [W-1:0] x, input logic [W-1:0] y);
    return int'(x) < int'(y);
  endfunction

  function automatic logic m_ovf(input logic [W-1:0] x, input logic [W-1:0] y);
    int sx, sy, r;
    sx = (x >= 128) ? int'(x) - 256 : int'(x);
    sy = (y >= 128) ? int'(y) - 256 : int'(y);
    r  = sx - sy;
    return (r > 127) || (r < -128);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b1; a = 8'hAA; b = 8'h55;
    tick(); tick();
    checks++;
    if ({busy, done, diff, bout, ovf} !== 12'h000) begin
      errors++;
      $display("FAIL reset_state: busy=%b done=%b diff=%h bout=%b ovf=%b, want all 0",
               busy, done, diff, bout, ovf);
    end
    reset = 1'b0; start = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: busy=%b want 0", busy);
    end
  endtask

  // One operation; a/b scrambled during RUN; optional start re-pulse mid-run.
  task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                       input bit repulse, input string name);
    int lat, busy_cnt;
    logic [W-1:0] hold;
    a = ta; b = tb_v; start = 1'b1;
    tick();
    start = 1'b0;
    lat = 0; busy_cnt = 0;
    while (done !== 1'b1 && lat < 20) begin
      if (busy === 1'b1) busy_cnt++;
      a = W'($urandom); b = W'($urandom);
      if (repulse && lat == 2) begin a = 8'hFF; b = 8'hFF; start = 1'b1; end
      if (repulse && lat == 4) start = 1'b0;
      tick();
      lat++;
    end
    checks++;
    if (lat != 8) begin
      errors++;
      $display("FAIL %s_latency: done after %0d edges, want 8", name, lat);
    end
    checks++;
    if (busy_cnt != 8 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_busy: busy cycles=%0d busy_at_done=%b, want 8 and 0", name, busy_cnt, busy);
    end
    checks++;
    if (diff !== m_diff(ta, tb_v) || bout !== m_bout(ta, tb_v) || ovf !== m_ovf(ta, tb_v)) begin
      errors++;
      $display("FAIL %s_result: a=%h b=%h diff=%h bout=%b ovf=%b, want %h %b %b", name, ta, tb_v,
               diff, bout, ovf, m_diff(ta, tb_v), m_bout(ta, tb_v), m_ovf(ta, tb_v));
    end
    hold = diff;
    tick(); tick();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || diff !== hold) begin
      errors++;
      $display("FAIL %s_hold: done=%b busy=%b diff=%h, want 0 0 %h", name, done, busy, diff, hold);
    end
  endtask

  task automatic test_directed();
    do_op(8'h05, 8'h03, 1'b0, "d_05_03");
    do_op(8'h03, 8'h05, 1'b0, "d_03_05");
    do_op(8'h80, 8'h01, 1'b0, "d_80_01");
    do_op(8'h7F, 8'hFF, 1'b0, "d_7f_ff");
    do_op(8'h00, 8'h00, 1'b0, "d_00_00");
  endtask

  task automatic test_restart_ignored();
    do_op(8'h05, 8'h03, 1'b1, "repulse");
  endtask

  task automatic test_random();
    for (int i = 0; i < 20; i++)
      do_op(W'($urandom), W'($urandom), 1'b0, "random");
  endtask

  task automatic test_reset_mid_run();
    a = 8'h12; b = 8'h34; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if ({busy, done, diff, bout, ovf} !== 12'h000) begin
      errors++;
      $display("FAIL abort_state: busy=%b done=%b diff=%h bout=%b ovf=%b, want all 0",
               busy, done, diff, bout, ovf);
    end
    begin
      int seen;
      seen = 0;
      for (int i = 0; i < 12; i++) begin
        if (done === 1'b1 || busy === 1'b1) seen++;
        tick();
      end
      checks++;
      if (seen != 0) begin
        errors++;
        $display("FAIL abort_quiet: %0d cycles with busy/done, want 0", seen);
      end
    end
    do_op(8'h40, 8'hC0, 1'b0, "after_abort");
  endtask

  // start held high: accepts at edges 0,10,20,...; done on the 8th edge after each.
  task automatic test_back_to_back();
    logic [W-1:0] ea, eb;
    start = 1'b1;
    for (int op = 0; op < 6; op++) begin
      ea = W'($urandom); eb = W'($urandom);
      a = ea; b = eb;
      tick();
      for (int k = 1; k <= 9; k++) begin
        a = W'($urandom); b = W'($urandom);
        tick();
        if (k == 8) begin
          checks++;
          if (done !== 1'b1 || busy !== 1'b0 || diff !== m_diff(ea, eb) ||
              bout !== m_bout(ea, eb) || ovf !== m_ovf(ea, eb)) begin
            errors++;
            $display("FAIL b2b_result op%0d: done=%b busy=%b diff=%h bout=%b ovf=%b, want 1 0 %h %b %b",
                     op, done, busy, diff, bout, ovf, m_diff(ea, eb), m_bout(ea, eb), m_ovf(ea, eb));
          end
        end else begin
          checks++;
          if (done !== 1'b0) begin
            errors++;
            $display("FAIL b2b_done_early op%0d k=%0d: done=%b want 0", op, k, done);
          end
        end
      end
    end
    start = 1'b0;
    tick(); tick();
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; a = '0; b = '0;
    test_reset();
    test_directed();
    test_restart_ignored();
    test_random();
    test_reset_mid_run();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_serial_sub
